// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit upstream line request to a four-beat 64-bit
// physical-memory burst, in either direction.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [63:0]  pmem_wdata,
  input  logic [63:0]  pmem_rdata,
  input  logic         pmem_resp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] buf_q, buf_d;
  logic [7:0]   beat_lsb;

  assign beat_lsb = {cnt_q, 6'd0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        // Read wins when both requests are raised together.
        if (line_read) begin
          state_d = S_READ;
          cnt_d   = 2'd0;
          addr_d  = line_address;
        end else if (line_write) begin
          state_d = S_WRITE;
          cnt_d   = 2'd0;
          addr_d  = line_address;
          buf_d   = line_wdata;
        end
      end
      S_READ: begin
        if (pmem_resp) begin
          buf_d[beat_lsb +: 64] = pmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      buf_q   <= 256'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  assign pmem_read    = (state_q == S_READ);
  assign pmem_write   = (state_q == S_WRITE);
  assign pmem_address = {addr_q[31:5], 5'd0};
  assign pmem_wdata   = buf_q[beat_lsb +: 64];
  assign line_resp    = (state_q == S_DONE);
  assign line_rdata   = line_resp ? buf_q : 256'd0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: drives upstream and
// pmem sides, checks beats, lines, latency and reset behaviour.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int failures = 0;

  logic [255:0] exp_line[$];
  logic [63:0]  exp_wbeat[$];
  logic [31:0]  exp_addr;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops scoreboard entries as the DUT produces them.
  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      chk("pmem_addr", pmem_address, exp_addr);
      chk("req_excl", pmem_read & pmem_write, 0);
    end
    if (pmem_write && pmem_resp) begin
      if (exp_wbeat.size() == 0) chk("wbeat_unexp", 1, 0);
      else chk("pmem_wdata", pmem_wdata, exp_wbeat.pop_front());
    end
    if (line_resp) begin
      if (exp_line.size() == 0) chk("resp_unexp", 1, 0);
      else chk("line_rdata", line_rdata, exp_line.pop_front());
    end else begin
      chk("rdata_zero", line_rdata, 0);
    end
  end

  task automatic zero_outputs(input string tag);
    chk(tag, {line_resp, pmem_read, pmem_write,
              pmem_address, pmem_wdata}, 0);
    chk({tag, "_rdata"}, line_rdata, 0);
  endtask

  task automatic run_txn(input bit rd, input bit wr,
                         input logic [31:0] addr,
                         input logic [255:0] d,
                         input int g0, input int g1,
                         input int g2, input int g3,
                         input bit hold);
    int gaps[4];
    logic [1:0] req;
    gaps[0] = g0; gaps[1] = g1;
    gaps[2] = g2; gaps[3] = g3;
    req = rd ? 2'b10 : 2'b01;
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = rd ? ~d : d;
    exp_addr     = {addr[31:5], 5'd0};
    exp_line.push_back(d);
    if (!rd)
      for (int k = 0; k < 4; k++)
        exp_wbeat.push_back(d[k*64 +: 64]);
    @(negedge clk);
    chk("idle_gap", {pmem_read, pmem_write, line_resp}, 0);
    tick();
    line_wdata   = ~line_wdata;
    line_address = $urandom;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("stall_req", {pmem_read, pmem_write}, req);
        chk("stall_noresp", line_resp, 0);
        tick();
      end
      pmem_resp  = 1'b1;
      pmem_rdata = rd ? d[k*64 +: 64] : {$urandom, $urandom};
      @(negedge clk);
      chk("beat_req", {pmem_read, pmem_write}, req);
      tick();
    end
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("resp_cycle", line_resp, 1);
    chk("done_noreq", {pmem_read, pmem_write}, 0);
    if (!hold) begin
      line_read  = 1'b0;
      line_write = 1'b0;
    end
    tick();
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] d;
    rst = 1'b1;
    line_read = 1'b0;
    line_write = 1'b0;
    line_address = 32'hDEAD_BEEF;
    line_wdata = '1;
    pmem_rdata = '1;
    pmem_resp = 1'b0;
    exp_addr = 32'd0;
    tick();
    @(negedge clk);
    zero_outputs("reset_during");
    tick();
    rst = 1'b0;
    @(negedge clk);
    zero_outputs("reset_after");
    tick();

    // pmem_resp in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      zero_outputs("idle_resp");
      tick();
    end
    pmem_resp = 1'b0;

    // contiguous read
    run_txn(1, 0, 32'h0000_1234,
            {{4{16'h4444}}, {4{16'h3333}},
             {4{16'h2222}}, {4{16'h1111}}},
            0, 0, 0, 0, 0);

    // gapped write
    d = {{4{16'hD3D3}}, {4{16'hD2D2}},
         {4{16'hD1D1}}, {4{16'hD0D0}}};
    run_txn(0, 1, 32'hABCD_EF1F, d, 0, 1, 0, 2, 0);

    // read has priority over simultaneous write
    run_txn(1, 1, 32'h0000_0420, rand_line(), 0, 2, 0, 1, 0);

    // reset after two read beats aborts the burst
    line_read    = 1'b1;
    line_address = 32'h8000_0047;
    exp_addr     = 32'h8000_0040;
    tick();
    for (int k = 0; k < 2; k++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    line_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      zero_outputs("abort_idle");
      tick();
    end
    pmem_resp = 1'b0;
    run_txn(1, 0, 32'h8000_0047, rand_line(), 1, 0, 0, 0, 0);

    // request held through DONE: one IDLE gap, then re-accepted
    run_txn(1, 0, 32'h0000_5000, rand_line(), 0, 0, 0, 0, 1);
    run_txn(1, 0, 32'h0000_5000, rand_line(), 0, 0, 1, 0, 0);

    // random mix
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        run_txn(1, 0, $urandom, rand_line(),
                $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), 0);
      else
        run_txn(0, 1, $urandom, rand_line(),
                $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    @(negedge clk);
    chk("lines_left", exp_line.size(), 0);
    chk("wbeats_left", exp_wbeat.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
